// File: rtl/temp_sensor_reader_if.sv
// Sensor serial bus plus the filtered temperature outputs of temp_sensor_reader.
// master = the reader itself; slave = sensor and temperature consumer side.
interface temp_sensor_reader_if;
  logic       sdo;
  logic       sclk;
  logic       cs_n;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       sensor_fault;

  // Outputs are registered and held.
  // temp_valid is a one-cycle strobe with no ready/backpressure:
  // the consumer must take temperature in the cycle temp_valid is high.
  modport master (
    input  sdo,
    output sclk, cs_n, temperature, temp_valid, sensor_fault
  );

  modport slave (
    output sdo,
    input  sclk, cs_n, temperature, temp_valid, sensor_fault
  );
endinterface

// File: rtl/temp_sensor_reader.sv
// Polls a serial temperature sensor, saturates each byte to 0..31 and
// publishes a 4-sample moving average with a one-cycle valid strobe.
module temp_sensor_reader #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned SAMPLE_INTERVAL = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  temp_sensor_reader_if.master  bus,
  output logic [1:0]            fsm_state
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned INT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(SAMPLE_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t           state;
  logic [INT_W-1:0] int_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [4:0]       hist [4];
  logic             filled;

  logic [4:0]       sat;
  logic [4:0]       hist_next [4];
  logic [6:0]       sum;

  assign fsm_state = state;

  // History entry 0 is the newest sample; an empty history is seeded with the first sample.
  always_comb begin
    sat = (shreg > 8'd31) ? 5'd31 : shreg[4:0];
    if (!filled) begin
      for (int i = 0; i < 4; i++) hist_next[i] = sat;
    end else begin
      hist_next[0] = sat;
      hist_next[1] = hist[0];
      hist_next[2] = hist[1];
      hist_next[3] = hist[2];
    end
    sum = 7'(hist_next[0]) + 7'(hist_next[1]) + 7'(hist_next[2]) + 7'(hist_next[3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      int_cnt          <= '0;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      filled           <= 1'b0;
      bus.sclk         <= 1'b0;
      bus.cs_n         <= 1'b1;
      bus.temperature  <= 5'd20;
      bus.temp_valid   <= 1'b0;
      bus.sensor_fault <= 1'b0;
    end else begin
      bus.temp_valid <= 1'b0;
      // Free-running so frame starts stay exactly SAMPLE_INTERVAL apart.
      int_cnt <= (int_cnt == INT_LAST) ? '0 : int_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (int_cnt == INT_LAST) begin
            state    <= SHIFT;
            bus.cs_n <= 1'b0;
            bus.sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!bus.sclk) begin
              // Sample on the rising sclk edge; the sensor changed sdo on the falling one.
              bus.sclk <= 1'b1;
              shreg    <= {shreg[6:0], bus.sdo};
            end else begin
              bus.sclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                state    <= UPDATE;
                bus.cs_n <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        UPDATE: begin
          state <= IDLE;
          if (shreg == 8'hFF) begin
            bus.sensor_fault <= 1'b1;
          end else begin
            bus.sensor_fault <= 1'b0;
            for (int i = 0; i < 4; i++) hist[i] <= hist_next[i];
            filled          <= 1'b1;
            bus.temperature <= sum[6:2];
            bus.temp_valid  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/temp_sensor_reader.md
# temp_sensor_reader

Upstream front end for the thermostat controller: it polls an external serial temperature sensor, converts each 8-bit reading to the controller's 5-bit temperature (°C, saturating), smooths it with a 4-sample moving average, and presents a held `temperature` bus plus a one-cycle `temp_valid` strobe. Its `temperature[4:0]` drives the controller's temperature inputs directly, in place of board switches.

## Interface
- `CLK_DIV`, default 2: clk cycles per sclk half-period; legal range is ≥1.
- `SAMPLE_INTERVAL`, default 64: clk cycles between consecutive frame starts; must exceed 16*CLK_DIV+2.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `sdo` input 1: sensor serial data. Sensor changes it on sclk falling edge; MSB first.
- `sclk` output 1: serial clock to sensor; idles low.
- `cs_n` output 1: sensor chip select, active low.
- `temperature` output 5: filtered temperature in °C, 0–31, registered and held.
- `temp_valid` output 1: one-cycle pulse when `temperature` has been updated.
- `sensor_fault` output 1: high after an all-ones frame; cleared by the next good frame.

## Operation
- Reset values: `temperature`=5'd20 (neither heating nor cooling region), `temp_valid`=0, `sensor_fault`=0, `cs_n`=1, `sclk`=0. Reset also clears the interval counter, bit counter, shift register, history and `filled` flag, and puts the FSM in IDLE.
- Reset mid-frame: `cs_n`→1 and `sclk`→0 asynchronously. Partial bits are discarded. History is not updated.
- FSM states:
  - IDLE: the interval counter runs. When it reaches SAMPLE_INTERVAL-1 (first time: SAMPLE_INTERVAL cycles after reset release), go to SHIFT. The counter wraps to 0 and keeps running through the frame.
  - SHIFT: `cs_n`=0. `sclk` is low for CLK_DIV cycles, then high for CLK_DIV cycles, for each of 8 bits. `sdo` is sampled into an 8-bit shift register on the clk edge where `sclk` goes 0→1. After the 8th high phase, go to UPDATE.
  - UPDATE: lasts 1 cycle, with `cs_n`=1 and `sclk`=0. Processes the byte, then returns to IDLE.
- Byte processing in UPDATE:
  - If byte = 8'hFF: set `sensor_fault`=1. History, `temperature` and `temp_valid` are untouched.
  - Otherwise clear `sensor_fault` and compute s = (byte>31) ? 31 : byte[4:0].
  - If `filled`=0: write s into all 4 history entries and set `filled`.
  - Otherwise shift s into the history and drop the oldest entry.
  - Sum the 4 entries in 7 bits, with no overflow possible (max 124). Average = sum>>2, truncating toward zero.
  - Register the average into `temperature` and pulse `temp_valid`.
- A fault before the first good frame leaves `filled`=0 and `temperature`=20.
- The interval counter is never reset by frames. Frame starts are exactly SAMPLE_INTERVAL cycles apart.

## Timing
- Let k = the cycle `cs_n` falls.
- Bit i (i=0 is the MSB) is sampled at k+CLK_DIV*(2i+1); the last sample is at k+15*CLK_DIV.
- At k+16*CLK_DIV, `sclk` falls, `cs_n` rises, and the FSM enters UPDATE.
- `temperature`, `temp_valid` and `sensor_fault` change at k+16*CLK_DIV+1. `temp_valid` is high for exactly that one cycle.
- Next `cs_n` fall is at k+SAMPLE_INTERVAL.
- With defaults, `cs_n` is low for 32 cycles and outputs update 33 cycles after `cs_n` falls.
- `sclk` and `cs_n` are registered outputs and are glitch-free.

## Test plan
All scenarios use defaults and a behavioural sensor model that shifts a programmed byte MSB-first on sclk falling edges.
- Reset held, then released, with no frame yet → `temperature`=20, `temp_valid`=0, `sensor_fault`=0, `cs_n`=1, `sclk`=0. First `cs_n` fall occurs exactly 64 cycles after release.
- Sensor returns 8'd25 → `cs_n` low for 32 cycles with exactly 8 `sclk` rises. `temperature`=25 with `temp_valid` pulsed once, 33 cycles after `cs_n` fall.
- After 25, sensor returns 16 for four frames → successive `temperature` = 22, 20, 18, 16, one `temp_valid` per frame.
- Sensor returns 8'd200 on the first frame → `temperature`=31.
- After 25 settles, sensor returns 8'hFF → `sensor_fault`=1, `temperature` holds 25, no `temp_valid`. A next frame of 8'd25 → `sensor_fault`=0, `temperature`=25, `temp_valid` pulsed.
- `rst_n` asserted during bit 4 of a frame → `cs_n`=1 and `sclk`=0 immediately, `temperature`=20. After release, the next frame starts 64 cycles later and its byte 8'd10 gives `temperature`=10 (history refilled).
